// File: rtl/spi_pkg.sv
// Shared SPI types: slave FSM states, mode bundle, byte helpers.
// Used by the slave today and reusable by the master.
package spi_pkg;

    localparam int SPI_BYTE_BITS = 8;

    typedef enum logic {
        SLV_IDLE,
        SLV_ACTIVE
    } SpiSlaveState;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } SpiMode;

    typedef logic [SPI_BYTE_BITS-1:0] spi_byte_t;

    function automatic logic tx_bit(
        input spi_byte_t b,
        input bit        lsb
    );
        return lsb ? b[0] : b[SPI_BYTE_BITS-1];
    endfunction

    function automatic spi_byte_t tx_next(
        input spi_byte_t b,
        input bit        lsb
    );
        return lsb ? {1'b0, b[SPI_BYTE_BITS-1:1]}
                   : {b[SPI_BYTE_BITS-2:0], 1'b0};
    endfunction

    function automatic spi_byte_t rx_push(
        input spi_byte_t b,
        input logic      d,
        input bit        lsb
    );
        return lsb ? {d, b[SPI_BYTE_BITS-1:1]}
                   : {b[SPI_BYTE_BITS-2:0], d};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall strobes taken
// from the last two synchronized samples.
module spi_sync_edge #(
    parameter int STAGES = 2,
    parameter bit IDLE   = 1'b0
) (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (res) begin
            sync <= {STAGES{IDLE}};
            prev <= IDLE;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled sclk/mosi/cs, byte strobe out,
// ready/load holding register in.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic       miso,
    output logic       misoOe,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic [7:0] txData,
    input  logic       txLoad,
    output logic       txReady,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       underrun,
    output logic       frameErr
);

    logic sclk_unused_lvl, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_unused_rise, mosi_unused_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sclk (
        .clk (clk),
        .res (res),
        .d   (sclk),
        .q   (sclk_unused_lvl),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs (
        .clk (clk),
        .res (res),
        .d   (cs),
        .q   (cs_q),
        .rise(cs_rise),
        .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_mosi (
        .clk (clk),
        .res (res),
        .d   (mosi),
        .q   (mosi_q),
        .rise(mosi_unused_rise),
        .fall(mosi_unused_fall)
    );

    SpiSlaveState         state;
    SpiMode               mode_q;
    logic [2:0]           bit_cnt;
    spi_byte_t            rx_sh;
    spi_byte_t            tx_sh;
    spi_byte_t            hold;
    logic                 slot_pend;
    logic [SYNC_STAGES:0] fresh;
    logic                 armed;

    logic      lead, trail;
    logic      sample_edge, shift_edge;
    logic      start, slot_go, cpha_eff;
    spi_byte_t slot_byte, rx_next;

    always_comb begin
        lead        = mode_q.cpol ? sclk_fall : sclk_rise;
        trail       = mode_q.cpol ? sclk_rise : sclk_fall;
        sample_edge = mode_q.cpha ? trail : lead;
        // CPHA=0: the trailing edge after bit 8 must not clobber
        // the first bit of the next slot.
        shift_edge  = mode_q.cpha ? lead
                                  : (trail && bit_cnt != 3'd0);
        start       = state == SLV_IDLE && cs_fall && armed;
        slot_go     = start
                   || (state == SLV_ACTIVE && slot_pend && !cs_rise);
        cpha_eff    = start ? CPHA : mode_q.cpha;
        slot_byte   = txReady ? '0 : hold;
        rx_next     = rx_push(rx_sh, mosi_q, LSB_FIRST);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= SLV_IDLE;
            mode_q    <= '0;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            hold      <= '0;
            slot_pend <= 1'b0;
            fresh     <= '0;
            armed     <= 1'b0;
            miso      <= 1'b0;
            misoOe    <= 1'b0;
            txReady   <= 1'b1;
            rxData    <= '0;
            rxValid   <= 1'b0;
            underrun  <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            rxValid   <= 1'b0;
            underrun  <= 1'b0;
            frameErr  <= 1'b0;
            slot_pend <= 1'b0;
            // A cs fall is only trusted once cs has been seen high
            // with real samples, not the synchronizer preset.
            fresh <= {fresh[SYNC_STAGES-1:0], 1'b1};
            if (cs_rise || (fresh[SYNC_STAGES] && cs_q))
                armed <= 1'b1;

            unique case (state)
                SLV_IDLE: begin
                    if (start) begin
                        state   <= SLV_ACTIVE;
                        mode_q  <= '{cpol: CPOL, cpha: CPHA};
                        misoOe  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SLV_ACTIVE: begin
                    if (cs_rise) begin
                        state    <= SLV_IDLE;
                        misoOe   <= 1'b0;
                        miso     <= 1'b0;
                        bit_cnt  <= '0;
                        frameErr <= bit_cnt != 3'd0;
                    end else begin
                        if (sample_edge) begin
                            rx_sh   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rxData    <= rx_next;
                                rxValid   <= 1'b1;
                                slot_pend <= 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            miso  <= tx_bit(tx_sh, LSB_FIRST);
                            tx_sh <= tx_next(tx_sh, LSB_FIRST);
                        end
                    end
                end
                default: state <= SLV_IDLE;
            endcase

            if (slot_go) begin
                underrun <= txReady;
                txReady  <= 1'b1;
                if (cpha_eff) begin
                    tx_sh <= slot_byte;
                end else begin
                    miso  <= tx_bit(slot_byte, LSB_FIRST);
                    tx_sh <= tx_next(slot_byte, LSB_FIRST);
                end
            end

            if (txLoad && txReady) begin
                hold    <= txData;
                txReady <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized SPI master driving spi_slave; scoreboard checks
// received bytes, miso bytes and strobe counts against a model.
module tb_spi_slave;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       res, sclk, mosi, cs, miso, misoOe;
    logic       CPOL, CPHA, txLoad, txReady;
    logic       rxValid, underrun, frameErr;
    logic [7:0] txData, rxData;

    spi_slave #(.SYNC_STAGES(2), .LSB_FIRST(1'b1)) dut (
        .clk     (clk),
        .res     (res),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs      (cs),
        .miso    (miso),
        .misoOe  (misoOe),
        .CPOL    (CPOL),
        .CPHA    (CPHA),
        .txData  (txData),
        .txLoad  (txLoad),
        .txReady (txReady),
        .rxData  (rxData),
        .rxValid (rxValid),
        .underrun(underrun),
        .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         n_und = 0, n_ferr = 0;
    int         exp_und = 0, exp_ferr = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    logic [7:0] last_rx = 8'h00;
    logic [7:0] mon_e;
    logic [7:0] m_tx[4];
    logic [7:0] m_got[4];
    logic [7:0] m_exp[4];
    logic [7:0] tail;
    bit         ld_en[4];
    logic [7:0] ld_val[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rxValid === 1'b1) begin
            checks++;
            if (exp_rx.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got %02h want none",
                         rxData);
            end else begin
                mon_e = exp_rx.pop_front();
                last_rx = mon_e;
                if (rxData !== mon_e) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h want %02h",
                             rxData, mon_e);
                end
            end
        end
        if (underrun === 1'b1) n_und++;
        if (frameErr === 1'b1) n_ferr++;
    end

    task automatic wait_h(input bit ld, input logic [7:0] v);
        for (int i = 0; i < H; i++) begin
            if (i == 0 && ld) begin
                txData = v;
                txLoad = 1'b1;
            end
            @(posedge clk);
            #1;
            txLoad = 1'b0;
        end
    endtask

    task automatic preload(input logic [7:0] v);
        if (tx_q.size() == 0) begin
            chk("tx_ready_idle", 32'(txReady), 32'd1);
            tx_q.push_back(v);
            wait_h(1'b1, v);
        end else begin
            wait_h(1'b0, 8'h00);
        end
    endtask

    task automatic half(input bit at_mid, input int k);
        bit ld;
        ld = at_mid && ld_en[k] && tx_q.size() == 0;
        if (ld) begin
            chk("tx_ready_mid", 32'(txReady), 32'd1);
            tx_q.push_back(ld_val[k]);
        end
        wait_h(ld, ld_val[k]);
    endtask

    // One transfer slot: take the held byte, else 0x00 + underrun.
    task automatic slot_pop(input bit full, input logic [7:0] sent,
                            output logic [7:0] mo);
        if (tx_q.size() > 0) begin
            mo = tx_q.pop_front();
        end else begin
            mo = 8'h00;
            exp_und++;
        end
        if (full) exp_rx.push_back(sent);
    endtask

    task automatic setup();
        for (int k = 0; k < 4; k++) begin
            ld_en[k]  = 1'b0;
            ld_val[k] = 8'h00;
            m_tx[k]   = 8'h00;
        end
    endtask

    task automatic frame(input bit pol, input bit pha, input int nb,
                         input int last_bits, input bit close);
        int nbits;
        CPOL = pol;
        CPHA = pha;
        sclk = pol;
        mosi = 1'b0;
        wait_h(1'b0, 8'h00);
        wait_h(1'b0, 8'h00);
        for (int k = 0; k < nb; k++) begin
            nbits = (k == nb - 1) ? last_bits : 8;
            slot_pop(nbits == 8, m_tx[k], m_exp[k]);
            m_got[k] = 8'h00;
            if (k == 0) begin
                cs = 1'b0;
                if (pha) wait_h(1'b0, 8'h00);
            end
            for (int b = 0; b < nbits; b++) begin
                bit last;
                last = close && pha && k == nb - 1 && b == nbits - 1;
                if (!pha) begin
                    mosi = m_tx[k][b];
                    half(b == 3, k);
                    sclk = ~pol;
                    m_got[k][b] = miso;
                    wait_h(1'b0, 8'h00);
                    sclk = pol;
                end else begin
                    sclk = ~pol;
                    mosi = m_tx[k][b];
                    half(b == 3, k);
                    sclk = pol;
                    m_got[k][b] = miso;
                    if (last) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        wait_h(1'b0, 8'h00);
                    end
                end
                if (k == 0 && b == 0)
                    chk("miso_oe_sel", 32'(misoOe), 32'd1);
            end
        end
        if (!pha) wait_h(1'b0, 8'h00);
        if (close) begin
            // CPHA=0 keeps cs low past the post-byte slot start.
            if (!pha && last_bits == 8) slot_pop(1'b0, 8'h00, tail);
            if (last_bits != 8) exp_ferr++;
            cs = 1'b1;
            mosi = 1'b0;
            for (int i = 0; i < 3; i++) wait_h(1'b0, 8'h00);
            chk("miso_oe_idle", 32'(misoOe), 32'd0);
            chk("miso_idle", 32'(miso), 32'd0);
            chk("rx_drain", 32'(exp_rx.size()), 32'd0);
            chk("underrun_cnt", 32'(n_und), 32'(exp_und));
            chk("frame_err_cnt", 32'(n_ferr), 32'(exp_ferr));
            chk("rx_data_hold", 32'(rxData), 32'(last_rx));
            chk("tx_ready", 32'(txReady), 32'(tx_q.size() == 0));
            for (int k = 0; k < nb; k++)
                if (k < nb - 1 || last_bits == 8)
                    chk("miso_byte", 32'(m_got[k]), 32'(m_exp[k]));
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(misoOe), 32'd0);
        chk("rst_tx_ready", 32'(txReady), 32'd1);
        chk("rst_rx_data", 32'(rxData), 32'd0);
        chk("rst_rx_valid", 32'(rxValid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_frame_err", 32'(frameErr), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        res = 1'b1;
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        CPOL = 1'b0;
        CPHA = 1'b0;
        txLoad = 1'b0;
        txData = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs();
        res = 1'b0;
        wait_h(1'b0, 8'h00);
        wait_h(1'b0, 8'h00);

        setup();
        preload(8'h3C);
        m_tx[0] = 8'hA5;
        frame(1'b0, 1'b0, 1, 8, 1'b1);

        setup();
        preload(8'hF0);
        m_tx[0] = 8'h81;
        frame(1'b1, 1'b1, 1, 8, 1'b1);

        setup();
        preload(8'h55);
        ld_en[0] = 1'b1;
        ld_val[0] = 8'hAA;
        m_tx[0] = 8'h12;
        m_tx[1] = 8'h34;
        frame(1'b0, 1'b1, 2, 8, 1'b1);

        setup();
        m_tx[0] = 8'h6D;
        frame(1'b0, 1'b1, 1, 8, 1'b1);

        setup();
        m_tx[0] = 8'hE7;
        frame(1'b0, 1'b0, 1, 5, 1'b1);
        setup();
        preload(8'h99);
        m_tx[0] = 8'h7E;
        frame(1'b0, 1'b0, 1, 8, 1'b1);

        setup();
        preload(8'h5A);
        m_tx[0] = 8'h3B;
        frame(1'b0, 1'b0, 1, 3, 1'b0);
        res = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        res = 1'b0;
        tx_q.delete();
        last_rx = 8'h00;
        cs = 1'b1;
        for (int i = 0; i < 3; i++) wait_h(1'b0, 8'h00);
        chk("rst_no_frame_err", 32'(n_ferr), 32'(exp_ferr));
        chk("rst_idle_oe", 32'(misoOe), 32'd0);
        setup();
        preload(8'h24);
        m_tx[0] = 8'hC3;
        frame(1'b0, 1'b0, 1, 8, 1'b1);

        for (int r = 0; r < 20; r++) begin
            int nb;
            bit pol, pha;
            setup();
            nb  = $urandom_range(1, 3);
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                m_tx[k]   = 8'($urandom);
                ld_en[k]  = 1'($urandom_range(0, 1));
                ld_val[k] = 8'($urandom);
            end
            if ($urandom_range(0, 3) != 0) preload(8'($urandom));
            frame(pol, pha, nb, 8, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave/responder: the peer of the existing SPI master; handles one 8-bit byte per transfer slot and multiple bytes per cs-low frame.
- Oversamples sclk, mosi and cs in the system clock domain. Delivers received bytes as a one-cycle strobe and takes transmit bytes through a ready/load holding register.
- Sits between an external SPI pin group and the on-chip register/command logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer (minimum 2).
- LSB_FIRST, 1, 1 = bit 0 is transferred first, matching the master's bit order; 0 = MSB first.

Ports:
- clk  input  1  system clock.
- res  input  1  synchronous reset, active-high.
- sclk  input  1  SPI clock from the master (asynchronous).
- mosi  input  1  master-out data (asynchronous).
- cs  input  1  chip select, active-low (high = idle).
- miso  output  1  slave-out data.
- misoOe  output  1  miso output enable; high only while selected.
- CPOL  input  1  clock polarity.
- CPHA  input  1  clock phase.
- txData  input  8  byte to transmit.
- txLoad  input  1  writes txData into the holding register when txReady=1.
- txReady  output  1  holding register is empty.
- rxData  output  8  last complete received byte.
- rxValid  output  1  one-cycle strobe: rxData has just been updated.
- underrun  output  1  one-cycle strobe: a byte slot started with the holding register empty.
- frameErr  output  1  one-cycle strobe: cs rose while a byte was incomplete.

Behaviour:
- Reset values:
  - miso=0, misoOe=0, txReady=1, rxData=0, rxValid=0, underrun=0, frameErr=0.
  - Synchronizers are preset to the idle values cs=1, sclk=0, mosi=0.
  - State=SLV_IDLE, bit counter=0.
- Synchronization: sclk, mosi and cs each pass through SYNC_STAGES flip-flops. Edges are detected from the last two synchronized samples.
- Timing constraint: each sclk half-period must be at least SYNC_STAGES+3 clk cycles. The bench must respect this; behaviour outside it is undefined.
- Mode latching: CPOL and CPHA are captured on the clk cycle in which the cs falling edge is detected. They are ignored for the rest of the frame.
- Edges:
  - Leading edge = sclk leaving the CPOL level; trailing edge = sclk returning to it.
  - CPHA=0: sample mosi on the leading edge, shift miso on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- State machine:
  - SLV_IDLE -> SLV_ACTIVE on cs falling edge.
  - SLV_ACTIVE -> SLV_IDLE on cs rising edge, or on res.
- Byte slot start (cs fall, and the cycle after each completed byte while cs stays low):
  - If the holding register is full, move it into the tx shift register and set txReady=1.
  - If it is empty, load 0x00 into the tx shift register and pulse underrun.
  - CPHA=0: the first bit is on miso no later than 1 clk after the cs fall is detected.
  - CPHA=1: the first bit is driven on the first shift edge. miso holds 0 before that edge.
- Sampling: each sample edge shifts the synchronized mosi into the rx shift register and increments the bit counter (0..7, wraps).
- Byte completion: on the 8th sample edge, rxData updates and rxValid pulses in the following clk cycle. A new rxValid overwrites rxData without any acknowledge.
- Shifting: each shift edge presents the next tx bit. After the 8th bit, the next slot's first bit follows the slot-start rule.
- Holding register: txLoad && txReady captures txData and sets txReady=0 in the next cycle. txLoad while txReady=0 is ignored.
- Simultaneous txLoad and slot start in the same cycle: the slot takes the old holding content (or underruns), and the load is accepted in the same cycle.
- cs rise mid-byte:
  - Bit counter is cleared and the partial byte is discarded; no rxValid.
  - frameErr pulses if bit counter != 0.
  - misoOe=0 on the next cycle.
  - The holding register is kept.
- cs rise exactly after the 8th bit: rxValid pulses normally and frameErr does not.
- misoOe = selected (cs low, synchronized). miso = 0 while misoOe=0.
- res mid-frame: all outputs return to their reset values. The slave stays in SLV_IDLE until a fresh cs falling edge is detected.

Decomposition:
- Shared package spi_pkg:
  - typedef SpiSlaveState enum {SLV_IDLE, SLV_ACTIVE}.
  - Constant SPI_BYTE_BITS = 8.
  - Mode typedef struct {CPOL, CPHA}, also reusable by the master.
- Sub-module spi_sync_edge: a SYNC_STAGES synchronizer with rise/fall strobe outputs and an idle/reset value parameter. It is instantiated for sclk and cs. mosi uses only the synchronizer part.

Test Plan:
- Mode 0: preload txData=0x3C, then master sends 0xA5 LSB-first over 8 sclk cycles -> rxValid once with rxData=0xA5; miso sequence 0,0,1,1,1,1,0,0; txReady back to 1.
- Mode 3 (CPOL=1, CPHA=1): master sends 0x81, slave preloaded with 0xF0 -> rxData=0x81; master receives 0xF0.
- Back-to-back in mode 1: cs held low for 2 bytes 0x12, 0x34; slave loads 0x55 then 0xAA after the first txReady -> two rxValid strobes (0x12, 0x34); miso carries 0x55 then 0xAA; no underrun.
- Underrun: holding register empty at cs fall -> underrun pulses once; master receives 0x00; rxData still correct.
- Abort: cs rises after 5 sample edges -> frameErr pulses once; no rxValid; rxData unchanged; the next full frame with 0x7E gives rxData=0x7E.
- res pulsed after 3 bits, then a new frame with 0xC3 -> all outputs at reset values immediately after res; the next frame yields rxData=0xC3 and frameErr stays 0.
